lfsr_range_rng: RTL

//  Parametrised Fibonacci-LFSR random-number generator with a req/valid handshake.

---
 rtl/lfsr_range_rng.sv | 117 +++++++++++
 1 files changed

// File: rtl/lfsr_range_rng.sv
`default_nettype none
// ============================================================================
// lfsr_range_rng : Fibonacci-LFSR generator returning values in 0..RANGE-1
// Rev 1.0
// ============================================================================
module lfsr_range_rng #(
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'h0005,
    parameter int unsigned       OUT_W     = 2,
    parameter int unsigned       RANGE     = 3,
    parameter int unsigned       MAX_TRIES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              req_i,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              rnd_valid_o,
    output logic [OUT_W-1:0]  rnd_out_o,
    output logic              busy_o,
    output logic              lockup_fix_o
);

    localparam int unsigned       TRY_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [OUT_W:0]    RANGE_X  = (OUT_W + 1)'(RANGE);
    localparam logic [OUT_W-1:0]  RANGE_L  = OUT_W'(RANGE);
    localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } state_t;

    state_t              state_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [TRY_W-1:0]    tries_q;
    logic [OUT_W-1:0]    rnd_out_q;
    logic                rnd_valid_q;
    logic                busy_q;
    logic                lockup_fix_q;

    logic [LFSR_W-1:0]   w_lfsr_step;
    logic [OUT_W-1:0]    w_cand;
    logic                w_cand_ok;

    assign w_lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    // Candidate is taken from the state before this edge's step.
    assign w_cand      = lfsr_q[OUT_W-1:0];
    assign w_cand_ok   = ({1'b0, w_cand} < RANGE_X);

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q       <= SEED_EFF;
            state_q      <= ST_IDLE;
            tries_q      <= '0;
            rnd_out_q    <= '0;
            rnd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            lockup_fix_q <= 1'b0;
        end else begin
            rnd_valid_q  <= 1'b0;
            lockup_fix_q <= 1'b0;
            if (seed_load_i) begin
                lfsr_q  <= (seed_i == '0) ? SEED_EFF : seed_i;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (lfsr_q == '0) begin
                // Recovery edge: FSM and retry count are frozen.
                lfsr_q       <= SEED_EFF;
                lockup_fix_q <= 1'b1;
            end else begin
                if ((state_q == ST_DRAW) || enable_i) begin
                    lfsr_q <= w_lfsr_step;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (req_i) begin
                            state_q <= ST_DRAW;
                            tries_q <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_DRAW: begin
                        if (w_cand_ok) begin
                            rnd_out_q   <= w_cand;
                            rnd_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                        end else if (tries_q == LAST_TRY) begin
                            // Out of retries: fold the rejected value into range.
                            rnd_out_q   <= w_cand - RANGE_L;
                            rnd_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            tries_q <= tries_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rnd_valid_o  = rnd_valid_q;
    assign rnd_out_o    = rnd_out_q;
    assign busy_o       = busy_q;
    assign lockup_fix_o = lockup_fix_q;

endmodule
`default_nettype wire
